// File: rtl/ay_bus_master_if.sv
// ay_bus_master_if: host request/response handshake plus the AY control pins.
//   req/op/wdata      host -> bus master request (op 00 waddr, 01 wdata, 10 read)
//   busy/done/rdata   bus master -> host status and last read byte
//   aybdir/aybc2/aybc1, aya8, aya9_n  AY bus control and chip selects
// modport master: the bus master itself; modport slave: host/card side mirror.
// The bidirectional data bus ayd stays a plain inout port on the master.
interface ay_bus_master_if;
  logic       req;
  logic [1:0] op;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       aybdir;
  logic       aybc2;
  logic       aybc1;
  logic       aya8;
  logic       aya9_n;

  modport master (
    input  req, op, wdata,
    output busy, done, rdata, aybdir, aybc2, aybc1, aya8, aya9_n
  );

  modport slave (
    output req, op, wdata,
    input  busy, done, rdata, aybdir, aybc2, aybc1, aya8, aya9_n
  );
endinterface

// File: rtl/ay_bus_master.sv
// ay_bus_master: host-side initiator for the AY/YM bus. Turns single-word
// requests into timed SETUP/STROBE/HOLD/RECOV bus cycles.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         ay_bus_master_if.master (request handshake + AY control pins)
//   ayd         AY data bus, driven only for writes during SETUP..HOLD
module ay_bus_master #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 24,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_RECOV  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ay_bus_master_if.master bus,
  inout  wire  [7:0]      ayd
);
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] CODE_INACT = 3'b010;
  localparam logic [2:0] CODE_WADDR = 3'b111;
  localparam logic [2:0] CODE_WDATA = 3'b110;
  localparam logic [2:0] CODE_READ  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RECOV  = 3'd4
  } state_t;

  // Out-of-range timings would make the 6-bit counter wrap.
  if (T_SETUP < 1 || T_SETUP > 63 || T_STROBE < 4 || T_STROBE > 63 ||
      T_HOLD < 1 || T_HOLD > 63 || T_RECOV < 1 || T_RECOV > 63) begin : g_param_check
    $error("ay_bus_master: timing parameter out of legal range");
  end

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rdata;
  logic [2:0]       r_code, w_code_nxt;
  logic             r_a8, w_a8_nxt;
  logic             r_a9_n, w_a9_n_nxt;
  logic             r_oe, w_oe_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_cnt_zero;

  assign w_accept   = (r_state == S_IDLE) && bus.req && (bus.op != OP_RSVD);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_op_nxt   = w_accept ? bus.op : r_op;

  // State register, phase counter and request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_WADDR;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      if (w_accept) r_wdata <= bus.wdata;
    end
  end

  // Next state: each phase loads param-1 on entry and leaves when the count hits 0
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_W'(T_SETUP - 1);
        end
      end
      S_SETUP: if (w_cnt_zero) begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = CNT_W'(T_STROBE - 1);
      end
      S_STROBE: if (w_cnt_zero) begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = CNT_W'(T_HOLD - 1);
      end
      S_HOLD: if (w_cnt_zero) begin
        w_state_nxt = S_RECOV;
        w_cnt_nxt   = CNT_W'(T_RECOV - 1);
      end
      S_RECOV: if (w_cnt_zero) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with it
  always_comb begin
    w_code_nxt = CODE_INACT;
    w_a8_nxt   = 1'b0;
    w_a9_n_nxt = 1'b1;
    w_oe_nxt   = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    unique case (w_state_nxt)
      S_SETUP, S_HOLD: begin
        w_a8_nxt   = 1'b1;
        w_a9_n_nxt = 1'b0;
        w_oe_nxt   = (w_op_nxt != OP_READ);
        w_busy_nxt = 1'b1;
      end
      S_STROBE: begin
        w_a8_nxt   = 1'b1;
        w_a9_n_nxt = 1'b0;
        w_oe_nxt   = (w_op_nxt != OP_READ);
        w_busy_nxt = 1'b1;
        unique case (w_op_nxt)
          OP_WADDR: w_code_nxt = CODE_WADDR;
          OP_WDATA: w_code_nxt = CODE_WDATA;
          default:  w_code_nxt = CODE_READ;
        endcase
      end
      S_RECOV: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = (w_cnt_nxt == '0);
      end
      default: ;
    endcase
  end

  // Registered bus pins and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= CODE_INACT;
      r_a8   <= 1'b0;
      r_a9_n <= 1'b1;
      r_oe   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_code <= w_code_nxt;
      r_a8   <= w_a8_nxt;
      r_a9_n <= w_a9_n_nxt;
      r_oe   <= w_oe_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Read data is sampled at the edge that ends the last strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == S_STROBE && w_cnt_zero && r_op == OP_READ) begin
      r_rdata <= ayd;
    end
  end

  assign ayd        = r_oe ? r_wdata : {8{1'bz}};
  assign bus.aybdir = r_code[2];
  assign bus.aybc2  = r_code[1];
  assign bus.aybc1  = r_code[0];
  assign bus.aya8   = r_a8;
  assign bus.aya9_n = r_a9_n;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;
endmodule

// File: tb/tb_ay_bus_master.sv
// tb_ay_bus_master: directed + randomized bench for ay_bus_master with a
// cycle-index reference model, plus a second instance (T_STROBE=4) feeding a
// small card decoder model (2-stage resync, 2-sample filter).
module tb_ay_bus_master;
  localparam int TS  = 2;
  localparam int TST = 24;
  localparam int TH  = 2;
  localparam int TR  = 8;
  localparam int TOT = TS + TST + TH + TR;

  typedef struct packed {
    logic [2:0] code;
    logic       a8;
    logic       a9n;
    logic       busy;
    logic       done;
    logic [7:0] ayd;
    logic [7:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tb_rd_val = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  int n_cmp = 0;
  int n_err = 0;

  wire [7:0] ayd_m;
  wire [7:0] ayd_c;

  ay_bus_master_if m_if ();
  ay_bus_master_if c_if ();

  ay_bus_master #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .T_RECOV(TR)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if), .ayd(ayd_m)
  );

  ay_bus_master #(.T_SETUP(2), .T_STROBE(4), .T_HOLD(2), .T_RECOV(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(c_if), .ayd(ayd_c)
  );

  always #9 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu_m (ayd_m[g]);
    pullup pu_c (ayd_c[g]);
  end

  // Peripheral answers reads whenever the read code is on the bus
  assign ayd_m = ({m_if.aybdir, m_if.aybc2, m_if.aybc1} == 3'b011) ? tb_rd_val : 8'hzz;

  // Card decoder model on the T_STROBE=4 instance
  logic [2:0] c_s1 = 3'b010, c_s2 = 3'b010, c_prev = 3'b010, c_filt = 3'b010;
  int         cfg_strobes = 0;
  logic [7:0] cfg_val = 8'h00;
  always_ff @(posedge clk) begin
    c_s1   <= {c_if.aybdir, c_if.aybc2, c_if.aybc1};
    c_s2   <= c_s1;
    c_prev <= c_s2;
    if (c_s2 == c_prev) c_filt <= c_s2;
    if (c_s2 == c_prev && c_s2 == 3'b111 && c_filt != 3'b111 && c_if.aya8 && !c_if.aya9_n) begin
      cfg_strobes <= cfg_strobes + 1;
      cfg_val     <= ayd_c;
    end
  end

  function automatic logic [2:0] op_code(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b111;
      2'b01:   return 3'b110;
      default: return 3'b011;
    endcase
  endfunction

  // Expected pins at cycle k after acceptance (k=0 or past TOT means idle)
  function automatic exp_t model(input int k, input logic [1:0] op, input logic [7:0] wd,
                                 input logic [7:0] rdv, input logic [7:0] rd_prev);
    exp_t e;
    bit   sel;
    sel     = (k >= 1 && k <= TS + TST + TH);
    e.busy  = (k >= 1 && k <= TOT);
    e.done  = (k == TOT);
    e.a8    = sel;
    e.a9n   = !sel;
    e.code  = (k > TS && k <= TS + TST) ? op_code(op) : 3'b010;
    if (sel && op != 2'b10)  e.ayd = wd;
    else if (e.code == 3'b011) e.ayd = rdv;
    else                     e.ayd = 8'hFF;
    e.rdata = (op == 2'b10 && k > TS + TST) ? rdv : rd_prev;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic check_bus(input string tag, input exp_t e);
    chk({tag, " code"},  8'({m_if.aybdir, m_if.aybc2, m_if.aybc1}), 8'(e.code));
    chk({tag, " a8"},    8'(m_if.aya8),   8'(e.a8));
    chk({tag, " a9n"},   8'(m_if.aya9_n), 8'(e.a9n));
    chk({tag, " ayd"},   ayd_m,           e.ayd);
    chk({tag, " busy"},  8'(m_if.busy),   8'(e.busy));
    chk({tag, " done"},  8'(m_if.done),   8'(e.done));
    chk({tag, " rdata"}, m_if.rdata,      e.rdata);
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle cycle after done
  task automatic run_txn(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] rdv,
                         input bit hold, input bit noise);
    m_if.req   = 1'b1;
    m_if.op    = op;
    m_if.wdata = wd;
    tb_rd_val  = rdv;
    for (int k = 1; k <= TOT + 1; k++) begin
      @(negedge clk);
      check_bus($sformatf("op%0d k%0d", op, k), model(k, op, wd, rdv, exp_rdata));
      if (noise && k < TOT) begin
        m_if.req   = 1'($urandom_range(0, 1));
        m_if.op    = 2'($urandom_range(0, 3));
        m_if.wdata = 8'($urandom);
      end else begin
        m_if.req = hold;
      end
    end
    if (op == 2'b10) exp_rdata = rdv;
  endtask

  initial begin
    logic [7:0] wd;
    logic [1:0] op;
    int busy_cycles;
    int done_cnt;

    m_if.req = 1'b0; m_if.op = 2'b00; m_if.wdata = 8'h00;
    c_if.req = 1'b0; c_if.op = 2'b00; c_if.wdata = 8'h00;

    repeat (3) @(negedge clk);
    check_bus("reset", model(0, 2'b00, 8'h00, 8'h00, exp_rdata));
    rst_n = 1'b1;

    run_txn(2'b00, 8'h07, 8'h00, 1'b0, 1'b0);
    run_txn(2'b01, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_txn(2'b10, 8'h5A, 8'hA5, 1'b0, 1'b0);

    // req held high across back-to-back cycles with alternating ops
    run_txn(2'b00, 8'($urandom), 8'h00, 1'b1, 1'b0);
    run_txn(2'b10, 8'($urandom) & 8'h7F, 8'($urandom), 1'b1, 1'b0);
    run_txn(2'b01, 8'($urandom), 8'h00, 1'b1, 1'b0);
    run_txn(2'b10, 8'($urandom) & 8'h7F, 8'($urandom), 1'b0, 1'b0);

    // req chatter while busy must not start extra cycles
    run_txn(2'b01, 8'($urandom), 8'h00, 1'b0, 1'b1);
    run_txn(2'b10, 8'($urandom) & 8'h7F, 8'($urandom), 1'b0, 1'b1);

    // reserved op: nothing happens
    m_if.req = 1'b1; m_if.op = 2'b11; m_if.wdata = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_bus($sformatf("op3 c%0d", k), model(0, 2'b00, 8'h00, 8'h00, exp_rdata));
    end
    m_if.req = 1'b0;

    // reset during the strobe of a write
    wd = 8'($urandom) & 8'h7F;
    m_if.req = 1'b1; m_if.op = 2'b00; m_if.wdata = wd;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check_bus($sformatf("prerst k%0d", k), model(k, 2'b00, wd, 8'h00, exp_rdata));
      m_if.req = 1'b0;
    end
    rst_n = 1'b0;
    exp_rdata = 8'h00;
    #1;
    check_bus("async rst", model(0, 2'b00, 8'h00, 8'h00, exp_rdata));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bus($sformatf("in rst c%0d", k), model(0, 2'b00, 8'h00, 8'h00, exp_rdata));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_bus("post rst", model(0, 2'b00, 8'h00, 8'h00, exp_rdata));
    run_txn(2'b00, 8'($urandom), 8'h00, 1'b0, 1'b0);

    // randomized mix
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 2));
      wd = (op == 2'b10) ? (8'($urandom) & 8'h7F) : 8'($urandom);
      run_txn(op, wd, 8'($urandom), (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0,
              1'($urandom_range(0, 1)));
    end

    // config-port write through the card model with the short strobe instance
    busy_cycles = 0;
    done_cnt    = 0;
    c_if.req = 1'b1; c_if.op = 2'b00; c_if.wdata = 8'hF3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      c_if.req = 1'b0;
      if (c_if.busy) busy_cycles++;
      if (c_if.done) done_cnt++;
    end
    chk("cfg strobes", 8'(cfg_strobes), 8'd1);
    chk("cfg value",   cfg_val,         8'hF3);
    chk("cfg busy",    8'(busy_cycles), 8'd16);
    chk("cfg done",    8'(done_cnt),    8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
